// File: rtl/hsv_pkg.sv
// Shared widths, constants and helpers for the HSV to RGB conversion pipeline.
package hsv_pkg;

    localparam int H_W        = 9;
    localparam int S_W        = 11;
    localparam int V_W        = 8;
    localparam int RGB_W      = 8;
    localparam int HUE_SECTOR = 60;
    localparam int HUE_MAX    = 360;
    localparam int RECIP60    = 17477;
    localparam int RECIP60_SH = 20;
    localparam int S_FULL_SH  = 11;

    localparam int F_W  = 6;
    localparam int T_W  = 14;
    localparam int VS_W = V_W + S_W + 1;

    typedef enum logic [2:0] {
        SECT_0 = 3'd0,
        SECT_1 = 3'd1,
        SECT_2 = 3'd2,
        SECT_3 = 3'd3,
        SECT_4 = 3'd4,
        SECT_5 = 3'd5
    } sector_e;

    function automatic logic add_ovf(input logic [RGB_W-1:0] a, input logic [RGB_W-1:0] b);
        logic [RGB_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[RGB_W];
    endfunction

    function automatic logic [RGB_W-1:0] sat_add(input logic [RGB_W-1:0] a, input logic [RGB_W-1:0] b);
        logic [RGB_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[RGB_W] ? {RGB_W{1'b1}} : sum[RGB_W-1:0];
    endfunction

endpackage

// File: rtl/hsv_to_rgb_math_if.sv
// Pixel stream bundle: HSV pixel plus valid/sideband in, RGB pixel plus valid/sideband out.
interface hsv_to_rgb_math_if
    import hsv_pkg::*;
#(
    parameter int SB_W = 2
);

    logic             valid_in;
    logic [SB_W-1:0]  sb_in;
    logic [H_W-1:0]   H_in;
    logic [S_W-1:0]   S_in;
    logic [V_W-1:0]   V_in;
    logic             valid_out;
    logic [SB_W-1:0]  sb_out;
    logic [RGB_W-1:0] R_out;
    logic [RGB_W-1:0] G_out;
    logic [RGB_W-1:0] B_out;

    modport master (
        output valid_in, sb_in, H_in, S_in, V_in,
        input  valid_out, sb_out, R_out, G_out, B_out
    );

    modport slave (
        input  valid_in, sb_in, H_in, S_in, V_in,
        output valid_out, sb_out, R_out, G_out, B_out
    );

endinterface

// File: rtl/hsv_div60.sv
// Registered exact divide-by-60 of a 14-bit value via fixed-point reciprocal multiply.
module hsv_div60
    import hsv_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [T_W-1:0]   t,
    output logic [RGB_W-1:0] q
);

    localparam int PROD_W = T_W + 15;

    logic [PROD_W-1:0] prod_s;
    logic [RGB_W-1:0]  q_r;

    // Reciprocal product; exact floor(t/60) for every t up to 15300
    always_comb begin
        prod_s = PROD_W'(t) * PROD_W'(RECIP60);
    end

    // Quotient register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= '0;
        end else begin
            q_r <= RGB_W'(prod_s >> RECIP60_SH);
        end
    end

    assign q = q_r;

endmodule

// File: rtl/hsv_to_rgb_math_chk.sv
// Simulation checks: valid latency tracking and the never-expected saturation hit.
module hsv_to_rgb_math_chk #(
    parameter int LATENCY = 5
) (
    input logic clk,
    input logic rst_n,
    input logic valid_in,
    input logic valid_out,
    input logic sat_hit
);

    logic [LATENCY-1:0] vld_hist_r;

    // Expected valid delay line, cleared by the same reset as the pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_hist_r <= '0;
        end else begin
            vld_hist_r <= {vld_hist_r[LATENCY-2:0], valid_in};
        end
    end

    a_latency: assert property (@(posedge clk) disable iff (!rst_n) valid_out == vld_hist_r[LATENCY-1]);
    a_no_sat:  assert property (@(posedge clk) disable iff (!rst_n) !sat_hit);

endmodule

// File: rtl/hsv_to_rgb_math.sv
// Five-stage HSV to RGB converter, one pixel per clock, valid and sideband carried in lockstep.
module hsv_to_rgb_math
    import hsv_pkg::*;
#(
    parameter int SB_W    = 2,
    parameter int LATENCY = 5
) (
    input logic              clk,
    input logic              rst_n,
    hsv_to_rgb_math_if.slave px
);

    logic [H_W-1:0]   hw_s;
    logic [H_W-1:0]   base_s;
    sector_e          sector_s;
    logic [F_W-1:0]   f_s;
    logic [VS_W-1:0]  vs_round_s;
    logic [V_W-1:0]   c_s;
    logic [F_W-1:0]   f_comp_s;
    logic [T_W-1:0]   tu_s;
    logic [T_W-1:0]   td_s;
    logic [RGB_W-1:0] xu_s;
    logic [RGB_W-1:0] xd_s;
    logic [RGB_W-1:0] mxu_s;
    logic [RGB_W-1:0] mxd_s;
    logic [RGB_W-1:0] r_s;
    logic [RGB_W-1:0] g_s;
    logic [RGB_W-1:0] b_s;
    logic             sat_hit_s;

    logic             s1_valid_r, s2_valid_r, s3_valid_r, s4_valid_r, out_valid_r;
    logic [SB_W-1:0]  s1_sb_r, s2_sb_r, s3_sb_r, s4_sb_r, out_sb_r;
    sector_e          s1_sector_r, s2_sector_r, s3_sector_r, s4_sector_r;
    logic [F_W-1:0]   s1_f_r, s2_f_r;
    logic [S_W-1:0]   s1_s_r;
    logic [V_W-1:0]   s1_v_r, s2_v_r, s3_v_r, s4_v_r;
    logic [V_W-1:0]   s2_c_r, s3_c_r;
    logic [T_W-1:0]   s3_tu_r, s3_td_r;
    logic [RGB_W-1:0] s4_m_r;
    logic [RGB_W-1:0] out_r_r, out_g_r, out_b_r;

    // Hue wrap and sector/fraction split; Hw never exceeds 359 so a compare chain suffices
    always_comb begin
        sector_s = SECT_0;
        base_s   = '0;
        hw_s     = (px.H_in >= H_W'(HUE_MAX)) ? (px.H_in - H_W'(HUE_MAX)) : px.H_in;
        if (hw_s >= H_W'(5 * HUE_SECTOR)) begin
            sector_s = SECT_5;
            base_s   = H_W'(5 * HUE_SECTOR);
        end else if (hw_s >= H_W'(4 * HUE_SECTOR)) begin
            sector_s = SECT_4;
            base_s   = H_W'(4 * HUE_SECTOR);
        end else if (hw_s >= H_W'(3 * HUE_SECTOR)) begin
            sector_s = SECT_3;
            base_s   = H_W'(3 * HUE_SECTOR);
        end else if (hw_s >= H_W'(2 * HUE_SECTOR)) begin
            sector_s = SECT_2;
            base_s   = H_W'(2 * HUE_SECTOR);
        end else if (hw_s >= H_W'(HUE_SECTOR)) begin
            sector_s = SECT_1;
            base_s   = H_W'(HUE_SECTOR);
        end else begin
            sector_s = SECT_0;
            base_s   = '0;
        end
        f_s = F_W'(hw_s - base_s);
    end

    // Chroma with round-to-nearest, then the rising/falling ramp products
    always_comb begin
        vs_round_s = VS_W'(s1_v_r) * VS_W'(s1_s_r) + VS_W'(1 << (S_FULL_SH - 1));
        c_s        = V_W'(vs_round_s >> S_FULL_SH);
        f_comp_s   = F_W'(HUE_SECTOR) - s2_f_r;
        tu_s       = T_W'(s2_c_r) * T_W'(s2_f_r);
        td_s       = T_W'(s2_c_r) * T_W'(f_comp_s);
    end

    // Stages 1-4 pipeline registers; div60 instances supply the stage-4 quotients
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r  <= 1'b0;
            s1_sb_r     <= '0;
            s1_sector_r <= SECT_0;
            s1_f_r      <= '0;
            s1_s_r      <= '0;
            s1_v_r      <= '0;
            s2_valid_r  <= 1'b0;
            s2_sb_r     <= '0;
            s2_sector_r <= SECT_0;
            s2_f_r      <= '0;
            s2_v_r      <= '0;
            s2_c_r      <= '0;
            s3_valid_r  <= 1'b0;
            s3_sb_r     <= '0;
            s3_sector_r <= SECT_0;
            s3_v_r      <= '0;
            s3_c_r      <= '0;
            s3_tu_r     <= '0;
            s3_td_r     <= '0;
            s4_valid_r  <= 1'b0;
            s4_sb_r     <= '0;
            s4_sector_r <= SECT_0;
            s4_v_r      <= '0;
            s4_m_r      <= '0;
        end else begin
            s1_valid_r  <= px.valid_in;
            s1_sb_r     <= px.sb_in;
            s1_sector_r <= sector_s;
            s1_f_r      <= f_s;
            s1_s_r      <= px.S_in;
            s1_v_r      <= px.V_in;
            s2_valid_r  <= s1_valid_r;
            s2_sb_r     <= s1_sb_r;
            s2_sector_r <= s1_sector_r;
            s2_f_r      <= s1_f_r;
            s2_v_r      <= s1_v_r;
            s2_c_r      <= c_s;
            s3_valid_r  <= s2_valid_r;
            s3_sb_r     <= s2_sb_r;
            s3_sector_r <= s2_sector_r;
            s3_v_r      <= s2_v_r;
            s3_c_r      <= s2_c_r;
            s3_tu_r     <= tu_s;
            s3_td_r     <= td_s;
            s4_valid_r  <= s3_valid_r;
            s4_sb_r     <= s3_sb_r;
            s4_sector_r <= s3_sector_r;
            s4_v_r      <= s3_v_r;
            s4_m_r      <= s3_v_r - s3_c_r;
        end
    end

    hsv_div60 u_div_up (
        .clk   (clk),
        .rst_n (rst_n),
        .t     (s3_tu_r),
        .q     (xu_s)
    );

    hsv_div60 u_div_dn (
        .clk   (clk),
        .rst_n (rst_n),
        .t     (s3_td_r),
        .q     (xd_s)
    );

    // Sector output mux; m+X cannot exceed V, the clamp only guards against a broken invariant
    always_comb begin
        r_s       = '0;
        g_s       = '0;
        b_s       = '0;
        mxu_s     = sat_add(s4_m_r, xu_s);
        mxd_s     = sat_add(s4_m_r, xd_s);
        sat_hit_s = add_ovf(s4_m_r, xu_s) | add_ovf(s4_m_r, xd_s);
        case (s4_sector_r)
            SECT_0:  begin r_s = s4_v_r; g_s = mxu_s;  b_s = s4_m_r; end
            SECT_1:  begin r_s = mxd_s;  g_s = s4_v_r; b_s = s4_m_r; end
            SECT_2:  begin r_s = s4_m_r; g_s = s4_v_r; b_s = mxu_s;  end
            SECT_3:  begin r_s = s4_m_r; g_s = mxd_s;  b_s = s4_v_r; end
            SECT_4:  begin r_s = mxu_s;  g_s = s4_m_r; b_s = s4_v_r; end
            SECT_5:  begin r_s = s4_v_r; g_s = s4_m_r; b_s = mxd_s;  end
            default: begin r_s = '0;     g_s = '0;     b_s = '0;     end
        endcase
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_sb_r    <= '0;
            out_r_r     <= '0;
            out_g_r     <= '0;
            out_b_r     <= '0;
        end else begin
            out_valid_r <= s4_valid_r;
            out_sb_r    <= s4_sb_r;
            out_r_r     <= r_s;
            out_g_r     <= g_s;
            out_b_r     <= b_s;
        end
    end

    assign px.valid_out = out_valid_r;
    assign px.sb_out    = out_sb_r;
    assign px.R_out     = out_r_r;
    assign px.G_out     = out_g_r;
    assign px.B_out     = out_b_r;

    hsv_to_rgb_math_chk #(
        .LATENCY (LATENCY)
    ) u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (px.valid_in),
        .valid_out (px.valid_out),
        .sat_hit   (sat_hit_s)
    );

endmodule

// File: tb/tb_hsv_to_rgb_math.sv
// Bench for hsv_to_rgb_math: directed pixels, full-rate hue sweep and mid-stream reset against a reference model.
module tb_hsv_to_rgb_math;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    logic [26:0] exp_q[$];
    string       tag_q[$];
    logic [1:0]  sb_cnt;

    hsv_to_rgb_math_if #(.SB_W(2)) px ();

    hsv_to_rgb_math #(
        .SB_W    (2),
        .LATENCY (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .px    (px)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference conversion using plain integer arithmetic on the colour model
    function automatic logic [23:0] ref_rgb(input int h, input int s, input int v);
        int hw, sec, f, c, m, xu, xd, r, g, b;
        hw  = (h >= 360) ? h - 360 : h;
        sec = hw / 60;
        f   = hw % 60;
        c   = (v * s + 1024) / 2048;
        m   = v - c;
        xu  = (c * f) / 60;
        xd  = (c * (60 - f)) / 60;
        case (sec)
            0: begin r = v;      g = m + xu; b = m;      end
            1: begin r = m + xd; g = v;      b = m;      end
            2: begin r = m;      g = v;      b = m + xu; end
            3: begin r = m;      g = m + xd; b = v;      end
            4: begin r = m + xu; g = m;      b = v;      end
            default: begin r = v; g = m;     b = m + xd; end
        endcase
        return {r[7:0], g[7:0], b[7:0]};
    endfunction

    function automatic logic [26:0] observed();
        return {px.valid_out, px.sb_out, px.R_out, px.G_out, px.B_out};
    endfunction

    task automatic check_step();
        logic [26:0] exp;
        string       tag;
        if (exp_q.size() == 5) begin
            exp = exp_q.pop_front();
            tag = tag_q.pop_front();
            checks++;
            assert (observed() === exp) else begin
                errors++;
                $error("FAIL %s: observed v/sb/rgb=%h expected=%h", tag, observed(), exp);
            end
        end else begin
            checks++;
            assert (px.valid_out === 1'b0) else begin
                errors++;
                $error("FAIL pipe_fill_valid: observed valid_out=%b expected=0", px.valid_out);
            end
        end
    endtask

    task automatic check_zero(input string tag);
        checks++;
        assert (observed() === 27'd0) else begin
            errors++;
            $error("FAIL %s: observed v/sb/rgb=%h expected=0", tag, observed());
        end
    endtask

    task automatic push(input logic [8:0] h, input logic [10:0] s, input logic [7:0] v,
                        input logic vld, input logic [1:0] sb, input logic [23:0] rgb, input string tag);
        px.H_in     = h;
        px.S_in     = s;
        px.V_in     = v;
        px.valid_in = vld;
        px.sb_in    = sb;
        exp_q.push_back({vld, sb, rgb});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        check_step();
    endtask

    initial begin
        logic [8:0]  h;
        logic [10:0] s;
        logic [7:0]  v;
        logic [1:0]  sb;
        logic        vld;
        errors      = 0;
        checks      = 0;
        sb_cnt      = 2'd0;
        rst_n       = 1'b0;
        px.valid_in = 1'b0;
        px.sb_in    = 2'd0;
        px.H_in     = 9'd0;
        px.S_in     = 11'd0;
        px.V_in     = 8'd0;
        #1;
        check_zero("reset_state");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed pixels with hand-computed colours
        push(9'd0,   11'd2047, 8'd255, 1'b1, 2'd1, {8'd255, 8'd0,   8'd0},   "red_h0");
        push(9'd120, 11'd2047, 8'd255, 1'b1, 2'd2, {8'd0,   8'd255, 8'd0},   "green_h120");
        push(9'd240, 11'd2047, 8'd255, 1'b1, 2'd3, {8'd0,   8'd0,   8'd255}, "blue_h240");
        push(9'd30,  11'd1024, 8'd200, 1'b1, 2'd0, {8'd200, 8'd150, 8'd100}, "half_sat_h30");
        push(9'd200, 11'd0,    8'd77,  1'b1, 2'd1, {8'd77,  8'd77,  8'd77},  "sat0_grey");
        push(9'd359, 11'd2047, 8'd0,   1'b1, 2'd2, {8'd0,   8'd0,   8'd0},   "v0_black");
        push(9'd400, 11'd2047, 8'd255, 1'b1, 2'd3, {8'd255, 8'd170, 8'd0},   "wrap_h400");
        push(9'd60,  11'd2047, 8'd255, 1'b0, 2'd0, {8'd255, 8'd255, 8'd0},   "invalid_h60");

        // Full-rate hue sweep with random S, V, valid and sideband
        for (int i = 0; i < 512; i++) begin
            h   = 9'(i);
            s   = 11'($urandom_range(0, 2047));
            v   = 8'($urandom_range(0, 255));
            vld = 1'($urandom_range(0, 1));
            sb  = 2'($urandom_range(0, 3));
            push(h, s, v, vld, sb, ref_rgb(int'(h), int'(s), int'(v)), $sformatf("sweep_h%0d", i));
        end

        // Mid-stream reset: bright valid pixels in flight, then asynchronous clear
        for (int i = 0; i < 6; i++) begin
            push(9'd10, 11'd2047, 8'd250, 1'b1, sb_cnt, ref_rgb(10, 2047, 250), "pre_reset");
            sb_cnt = sb_cnt + 2'd1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset_clear");
        for (int i = 0; i < 3; i++) begin
            px.valid_in = 1'b1;
            px.sb_in    = sb_cnt;
            sb_cnt      = sb_cnt + 2'd1;
            @(posedge clk);
            #1;
            check_zero("held_in_reset");
        end
        exp_q.delete();
        tag_q.delete();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            h = 9'($urandom_range(0, 511));
            s = 11'($urandom_range(0, 2047));
            v = 8'($urandom_range(0, 255));
            push(h, s, v, 1'b1, sb_cnt, ref_rgb(int'(h), int'(s), int'(v)), "post_reset");
            sb_cnt = sb_cnt + 2'd1;
        end

        // Drain the pipeline with idle pixels
        for (int i = 0; i < 5; i++) begin
            push(9'd0, 11'd0, 8'd0, 1'b0, 2'd0, 24'd0, "drain");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
